mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, between the EX/MEM pipeline register and `mem_wb`. It decodes the load or store operation, drives a request/acknowledge data bus with byte enables and lane-replicated store data, and extracts and extends load data. While an access is outstanding it requests a pipeline stall. It holds the completed result until the pipeline advances, so each access reaches the bus exactly once.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data bus request/acknowledge bundle driven by the MEM stage
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with byte-lane bus and load extension
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_mem,
  input  logic        ex_valid,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_sdata,
  input  logic [4:0]  ex_gpr_waddr,
  input  logic [31:0] ex_gpr_wdata,
  input  logic        ex_gpr_we,
  mem_stage_if.master dbus,
  output logic        stall_req_mem,
  output logic        excp_adel,
  output logic        excp_ades,
  output logic [4:0]  mem_gpr_waddr,
  output logic [31:0] mem_gpr_wdata,
  output logic        mem_gpr_we
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;

  // request context kept for load extraction once the bus answers
  logic [3:0]  req_op;
  logic [1:0]  req_lane;

  // completed result held until the pipeline advances
  logic [31:0] buf_wdata;
  logic [4:0]  buf_waddr;
  logic        buf_we;

  logic        is_load;
  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        mem_op;
  logic        aligned_op;
  logic [1:0]  lane;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic        req_is_load;
  logic [4:0]  shamt;
  logic [31:0] rshift;
  logic [31:0] load_result;

  assign lane = ex_mem_addr[1:0];

  // decode the incoming operation, alignment and lane-replicated store data
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_byte    = 1'b0;
    is_half    = 1'b0;
    is_word    = 1'b0;
    be_next    = 4'b0000;
    wdata_next = ex_mem_sdata;
    case (ex_mem_op)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        is_byte = 1'b1;
      end
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        is_half = 1'b1;
      end
      OP_LW: begin
        is_load = 1'b1;
        is_word = 1'b1;
      end
      OP_SB: begin
        is_store = 1'b1;
        is_byte  = 1'b1;
      end
      OP_SH: begin
        is_store = 1'b1;
        is_half  = 1'b1;
      end
      OP_SW: begin
        is_store = 1'b1;
        is_word  = 1'b1;
      end
      default: begin
        is_load  = 1'b0;
        is_store = 1'b0;
      end
    endcase

    if (is_byte) begin
      be_next    = 4'b0001 << lane;
      wdata_next = {4{ex_mem_sdata[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << lane;
      wdata_next = {2{ex_mem_sdata[15:0]}};
    end else if (is_word) begin
      be_next    = 4'b1111;
      wdata_next = ex_mem_sdata;
    end

    misaligned = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    mem_op     = ex_valid & (is_load | is_store);
    aligned_op = mem_op & ~misaligned;
  end

  assign req_is_load = (req_op >= OP_LB) && (req_op <= OP_LW);
  assign shamt       = {req_lane, 3'b000};
  assign rshift      = dbus.rdata >> shamt;

  // pick the addressed lane out of the response and extend it to 32 bits
  always_comb begin
    load_result = rshift;
    case (req_op)
      OP_LB:   load_result = {{24{rshift[7]}}, rshift[7:0]};
      OP_LBU:  load_result = {24'h000000, rshift[7:0]};
      OP_LH:   load_result = {{16{rshift[15]}}, rshift[15:0]};
      OP_LHU:  load_result = {16'h0000, rshift[15:0]};
      default: load_result = rshift;
    endcase
  end

  // access sequencer: issue once, wait for ack, hold the result until release
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dbus.req   <= 1'b0;
      dbus.we    <= 1'b0;
      dbus.be    <= 4'b0000;
      dbus.addr  <= 32'h0;
      dbus.wdata <= 32'h0;
      req_op     <= 4'd0;
      req_lane   <= 2'b00;
      buf_wdata  <= 32'h0;
      buf_waddr  <= 5'd0;
      buf_we     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aligned_op) begin
            dbus.req   <= 1'b1;
            dbus.we    <= is_store;
            dbus.be    <= be_next;
            dbus.addr  <= {ex_mem_addr[31:2], 2'b00};
            dbus.wdata <= wdata_next;
            req_op     <= ex_mem_op;
            req_lane   <= lane;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dbus.ack) begin
            dbus.req  <= 1'b0;
            dbus.we   <= 1'b0;
            dbus.be   <= 4'b0000;
            buf_wdata <= req_is_load ? load_result : ex_gpr_wdata;
            buf_waddr <= ex_gpr_waddr;
            buf_we    <= req_is_load & ex_gpr_we;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!stall_mem) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // writeback mux, stall request and alignment exceptions
  always_comb begin
    mem_gpr_waddr = ex_gpr_waddr;
    mem_gpr_wdata = ex_gpr_wdata;
    mem_gpr_we    = ex_gpr_we & ex_valid;
    stall_req_mem = 1'b0;
    excp_adel     = mem_op & is_load & misaligned;
    excp_ades     = mem_op & is_store & misaligned;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          mem_gpr_we = 1'b0;
        end
        if (aligned_op && !rst) begin
          stall_req_mem = 1'b1;
        end
      end
      S_WAIT: begin
        mem_gpr_we    = 1'b0;
        stall_req_mem = 1'b1;
      end
      S_DONE: begin
        mem_gpr_waddr = buf_waddr;
        mem_gpr_wdata = buf_wdata;
        mem_gpr_we    = buf_we;
      end
      default: begin
        stall_req_mem = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ext_stall;
  logic        stall_mem;
  logic        ex_valid;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_sdata;
  logic [4:0]  ex_gpr_waddr;
  logic [31:0] ex_gpr_wdata;
  logic        ex_gpr_we;
  logic        stall_req_mem;
  logic        excp_adel;
  logic        excp_ades;
  logic [4:0]  mem_gpr_waddr;
  logic [31:0] mem_gpr_wdata;
  logic        mem_gpr_we;

  int checks = 0;
  int errors = 0;

  mem_stage_if dbus ();

  always #5 clk = ~clk;

  // pipeline control freezes MEM on its own stall request plus any external stall
  assign stall_mem = stall_req_mem | ext_stall;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_mem     (stall_mem),
    .ex_valid      (ex_valid),
    .ex_mem_op     (ex_mem_op),
    .ex_mem_addr   (ex_mem_addr),
    .ex_mem_sdata  (ex_mem_sdata),
    .ex_gpr_waddr  (ex_gpr_waddr),
    .ex_gpr_wdata  (ex_gpr_wdata),
    .ex_gpr_we     (ex_gpr_we),
    .dbus          (dbus.master),
    .stall_req_mem (stall_req_mem),
    .excp_adel     (excp_adel),
    .excp_ades     (excp_ades),
    .mem_gpr_waddr (mem_gpr_waddr),
    .mem_gpr_wdata (mem_gpr_wdata),
    .mem_gpr_we    (mem_gpr_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata,
                            input int nwait, input int hold,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_res, input logic exp_gwe);
    logic exp_we;
    exp_we       = (op >= 4'd6);
    ex_valid     = 1'b1;
    ex_mem_op    = op;
    ex_mem_addr  = addr;
    ex_mem_sdata = sdata;
    ex_gpr_waddr = 5'd9;
    ex_gpr_wdata = 32'h5555_5555;
    ex_gpr_we    = 1'b1;
    #1;
    check("idle_stall", stall_req_mem, 1);
    check("idle_req", dbus.req, 0);
    check("idle_gwe", mem_gpr_we, 0);
    check("idle_adel", excp_adel, 0);
    tick();
    for (int i = 0; i <= nwait; i++) begin
      check("wait_req", dbus.req, 1);
      check("wait_be", dbus.be, exp_be);
      check("wait_addr", dbus.addr, {addr[31:2], 2'b00});
      check("wait_we", dbus.we, exp_we);
      if (exp_we) check("wait_wdata", dbus.wdata, exp_wdata);
      check("wait_stall", stall_req_mem, 1);
      check("wait_gwe", mem_gpr_we, 0);
      if (i == nwait) begin
        dbus.ack   = 1'b1;
        dbus.rdata = rdata;
      end
      tick();
      dbus.ack   = 1'b0;
      dbus.rdata = 32'h0;
    end
    check("done_req", dbus.req, 0);
    check("done_be", dbus.be, 0);
    check("done_we", dbus.we, 0);
    check("done_stall", stall_req_mem, 0);
    check("done_gwe", mem_gpr_we, exp_gwe);
    if (exp_gwe) begin
      check("done_wdata", mem_gpr_wdata, exp_res);
      check("done_waddr", mem_gpr_waddr, 9);
    end
    ext_stall = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      dbus.ack = 1'b1;
      tick();
      dbus.ack = 1'b0;
      check("hold_req", dbus.req, 0);
      check("hold_stall", stall_req_mem, 0);
      check("hold_gwe", mem_gpr_we, exp_gwe);
      if (exp_gwe) check("hold_wdata", mem_gpr_wdata, exp_res);
    end
    ext_stall = 1'b0;
    ex_valid  = 1'b0;
    tick();
    check("release_req", dbus.req, 0);
    check("release_stall", stall_req_mem, 0);
  endtask

  task automatic run_misaligned(input logic [3:0] op, input logic [31:0] addr,
                                input logic exp_adel, input logic exp_ades);
    ex_valid     = 1'b1;
    ex_mem_op    = op;
    ex_mem_addr  = addr;
    ex_gpr_we    = 1'b1;
    #1;
    check("mis_adel", excp_adel, exp_adel);
    check("mis_ades", excp_ades, exp_ades);
    check("mis_stall", stall_req_mem, 0);
    check("mis_gwe", mem_gpr_we, 0);
    tick();
    check("mis_req", dbus.req, 0);
    ex_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    ext_stall    = 1'b0;
    ex_valid     = 1'b0;
    ex_mem_op    = 4'd0;
    ex_mem_addr  = 32'h0;
    ex_mem_sdata = 32'h0;
    ex_gpr_waddr = 5'd0;
    ex_gpr_wdata = 32'h0;
    ex_gpr_we    = 1'b0;
    dbus.ack     = 1'b0;
    dbus.rdata   = 32'h0;
    tick();
    tick();
    check("rst_req", dbus.req, 0);
    check("rst_we", dbus.we, 0);
    check("rst_be", dbus.be, 0);
    check("rst_addr", dbus.addr, 0);
    check("rst_wdata", dbus.wdata, 0);
    check("rst_stall", stall_req_mem, 0);
    ex_valid    = 1'b1;
    ex_mem_op   = 4'd5;
    ex_mem_addr = 32'h0000_1004;
    #1;
    check("rst_op_stall", stall_req_mem, 0);
    ex_valid = 1'b0;
    rst      = 1'b0;
    tick();

    // aligned LW, ack in first request cycle
    run_access(4'd5, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1);
    // byte-lane loads
    run_access(4'd1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1);
    run_access(4'd2, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 4'b1000, 32'h0, 32'h0000_0080, 1'b1);
    // half store with three wait states
    run_access(4'd7, 32'h0000_2002, 32'hAAAA_1234, 32'h0, 3, 0, 4'b1100, 32'h1234_1234, 32'h0, 1'b0);
    // halfword loads, upper lane held under external stall
    run_access(4'd3, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 1, 3, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1);
    run_access(4'd4, 32'h0000_3000, 32'h0, 32'h8001_7FFF, 0, 0, 4'b0011, 32'h0, 32'h0000_7FFF, 1'b1);
    // byte and word stores
    run_access(4'd6, 32'h0000_4001, 32'h1234_565A, 32'h0, 0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0);
    run_access(4'd8, 32'h0000_4000, 32'h0123_4567, 32'h0, 1, 0, 4'b1111, 32'h0123_4567, 32'h0, 1'b0);

    // misaligned accesses
    run_misaligned(4'd5, 32'h0000_1001, 1'b1, 1'b0);
    run_misaligned(4'd7, 32'h0000_2001, 1'b0, 1'b1);
    run_misaligned(4'd4, 32'h0000_2003, 1'b1, 1'b0);
    run_misaligned(4'd8, 32'h0000_2002, 1'b0, 1'b1);

    // non-memory pass-through
    ex_valid     = 1'b1;
    ex_mem_op    = 4'd0;
    ex_gpr_waddr = 5'd7;
    ex_gpr_wdata = 32'h0000_CAFE;
    ex_gpr_we    = 1'b1;
    #1;
    check("pass_we", mem_gpr_we, 1);
    check("pass_wdata", mem_gpr_wdata, 32'h0000_CAFE);
    check("pass_waddr", mem_gpr_waddr, 7);
    check("pass_stall", stall_req_mem, 0);
    ex_mem_op = 4'd12;
    #1;
    check("op12_we", mem_gpr_we, 1);
    check("op12_stall", stall_req_mem, 0);
    ex_valid = 1'b0;
    #1;
    check("novalid_we", mem_gpr_we, 0);

    // stray ack while idle is ignored
    dbus.ack = 1'b1;
    tick();
    dbus.ack = 1'b0;
    check("stray_ack_req", dbus.req, 0);
    check("stray_ack_stall", stall_req_mem, 0);

    // reset during WAIT
    ex_valid    = 1'b1;
    ex_mem_op   = 4'd5;
    ex_mem_addr = 32'h0000_5000;
    ex_gpr_we   = 1'b1;
    tick();
    check("mid_req", dbus.req, 1);
    rst      = 1'b1;
    ex_valid = 1'b0;
    tick();
    check("mid_rst_req", dbus.req, 0);
    check("mid_rst_be", dbus.be, 0);
    check("mid_rst_stall", stall_req_mem, 0);
    rst = 1'b0;
    tick();
    run_access(4'd5, 32'h0000_5008, 32'h0, 32'h1357_9BDF, 0, 0, 4'b1111, 32'h0, 32'h1357_9BDF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
